// File: rtl/trap_sequencer_if.sv
// Pipeline <-> trap sequencer signal bundle. master = pipeline/CSR side, slave = sequencer.
interface trap_sequencer_if #(
  parameter int unsigned XLEN = 32
) ();
  logic            exc_req;
  logic [3:0]      exc_cause;
  logic [XLEN-1:0] exc_epc;
  logic [XLEN-1:0] exc_tval;
  logic            mret_req;
  logic            epc_valid;
  logic [XLEN-1:0] irq_epc;
  logic            extern_irpt;
  logic            timer_irpt;
  logic            soft_irpt;
  logic            mstatus_mie;
  logic [2:0]      mie_mask;
  logic            flush_ack;
  logic            flush_req;
  logic            busy;
  logic            trap_valid;
  logic [XLEN-1:0] trap_cause;
  logic [XLEN-1:0] trap_epc;
  logic [XLEN-1:0] trap_tval;
  logic            mret_valid;
  logic            timeout_err;

  modport master (
    output exc_req, exc_cause, exc_epc, exc_tval, mret_req, epc_valid, irq_epc,
           extern_irpt, timer_irpt, soft_irpt, mstatus_mie, mie_mask, flush_ack,
    input  flush_req, busy, trap_valid, trap_cause, trap_epc, trap_tval, mret_valid,
           timeout_err
  );

  modport slave (
    input  exc_req, exc_cause, exc_epc, exc_tval, mret_req, epc_valid, irq_epc,
           extern_irpt, timer_irpt, soft_irpt, mstatus_mie, mie_mask, flush_ack,
    output flush_req, busy, trap_valid, trap_cause, trap_epc, trap_tval, mret_valid,
           timeout_err
  );
endinterface

// File: rtl/trap_sequencer.sv
// Trap arbiter/sequencer: drains the pipeline, then commits one trap or mret to the CSRs.
// Optional IRQ_SYNC_EN: 2-flop synchronizers on the three machine interrupt inputs.
module trap_sequencer #(
  parameter int unsigned XLEN          = 32,
  parameter int unsigned DRAIN_TIMEOUT = 16,
  parameter int unsigned HOLDOFF       = 2
) (
  input  logic            i_clk,
  input  logic            i_rst,
  trap_sequencer_if.slave io_bus
);

  localparam int unsigned CntW = (DRAIN_TIMEOUT > 1) ? $clog2(DRAIN_TIMEOUT) : 1;
  localparam int unsigned HoW  = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(DRAIN_TIMEOUT - 1);
  localparam logic [HoW-1:0]  HoLoad  = HoW'(HOLDOFF);
  localparam logic [XLEN-1:0] CauseMei = {1'b1, {(XLEN-5){1'b0}}, 4'hB};
  localparam logic [XLEN-1:0] CauseMti = {1'b1, {(XLEN-5){1'b0}}, 4'h7};
  localparam logic [XLEN-1:0] CauseMsi = {1'b1, {(XLEN-5){1'b0}}, 4'h3};

  typedef enum logic [1:0] {StIdle, StDrain, StTrap, StMret} state_e;

  state_e          r_state;
  logic [CntW-1:0] r_drain_cnt;
  logic [HoW-1:0]  r_holdoff;
  logic [XLEN-1:0] r_cause;
  logic [XLEN-1:0] r_epc;
  logic [XLEN-1:0] r_tval;
  logic            r_flush_req;
  logic            r_busy;
  logic            r_trap_valid;
  logic [XLEN-1:0] r_trap_cause;
  logic [XLEN-1:0] r_trap_epc;
  logic [XLEN-1:0] r_trap_tval;
  logic            r_mret_valid;
  logic            r_timeout_err;

  logic [2:0] w_irq;  // {ext, timer, soft}
  logic       w_irq_ok;
  logic       w_take_ext;
  logic       w_take_tim;
  logic       w_take_sft;

`ifdef IRQ_SYNC_EN
  logic [2:0] r_irq_s1;
  logic [2:0] r_irq_s2;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_irq_s1 <= '0;
      r_irq_s2 <= '0;
    end else begin
      r_irq_s1 <= {io_bus.extern_irpt, io_bus.timer_irpt, io_bus.soft_irpt};
      r_irq_s2 <= r_irq_s1;
    end
  end

  assign w_irq = r_irq_s2;
`else
  assign w_irq = {io_bus.extern_irpt, io_bus.timer_irpt, io_bus.soft_irpt};
`endif

  assign w_irq_ok   = io_bus.mstatus_mie & io_bus.epc_valid & (r_holdoff == '0);
  assign w_take_ext = w_irq_ok & w_irq[2] & io_bus.mie_mask[2];
  assign w_take_tim = w_irq_ok & w_irq[1] & io_bus.mie_mask[1];
  assign w_take_sft = w_irq_ok & w_irq[0] & io_bus.mie_mask[0];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= StIdle;
      r_drain_cnt   <= '0;
      r_holdoff     <= '0;
      r_cause       <= '0;
      r_epc         <= '0;
      r_tval        <= '0;
      r_flush_req   <= 1'b0;
      r_busy        <= 1'b0;
      r_trap_valid  <= 1'b0;
      r_trap_cause  <= '0;
      r_trap_epc    <= '0;
      r_trap_tval   <= '0;
      r_mret_valid  <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_trap_valid <= 1'b0;
      r_trap_cause <= '0;
      r_trap_epc   <= '0;
      r_trap_tval  <= '0;
      r_mret_valid <= 1'b0;
      if (r_holdoff != '0) r_holdoff <= r_holdoff - 1'b1;

      unique case (r_state)
        StIdle: begin
          r_drain_cnt <= '0;
          if (io_bus.exc_req) begin
            r_cause     <= {{(XLEN-4){1'b0}}, io_bus.exc_cause};
            r_epc       <= io_bus.exc_epc;
            r_tval      <= io_bus.exc_tval;
            r_state     <= StDrain;
            r_flush_req <= 1'b1;
            r_busy      <= 1'b1;
          end else if (io_bus.mret_req) begin
            r_state      <= StMret;
            r_mret_valid <= 1'b1;
            r_busy       <= 1'b1;
          end else if (w_take_ext || w_take_tim || w_take_sft) begin
            r_cause     <= w_take_ext ? CauseMei : (w_take_tim ? CauseMti : CauseMsi);
            r_epc       <= io_bus.irq_epc;
            r_tval      <= '0;
            r_state     <= StDrain;
            r_flush_req <= 1'b1;
            r_busy      <= 1'b1;
          end
        end
        StDrain: begin
          // Give up waiting on the last counted cycle and trap anyway.
          if (io_bus.flush_ack || (r_drain_cnt == CntLast)) begin
            if (!io_bus.flush_ack) r_timeout_err <= 1'b1;
            r_state      <= StTrap;
            r_flush_req  <= 1'b0;
            r_trap_valid <= 1'b1;
            r_trap_cause <= r_cause;
            r_trap_epc   <= r_epc;
            r_trap_tval  <= r_tval;
          end else begin
            r_drain_cnt <= r_drain_cnt + 1'b1;
          end
        end
        StTrap: begin
          r_state <= StIdle;
          r_busy  <= 1'b0;
        end
        StMret: begin
          r_state   <= StIdle;
          r_busy    <= 1'b0;
          r_holdoff <= HoLoad;
        end
        default: begin
          r_state <= StIdle;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign io_bus.flush_req   = r_flush_req;
  assign io_bus.busy        = r_busy;
  assign io_bus.trap_valid  = r_trap_valid;
  assign io_bus.trap_cause  = r_trap_cause;
  assign io_bus.trap_epc    = r_trap_epc;
  assign io_bus.trap_tval   = r_trap_tval;
  assign io_bus.mret_valid  = r_mret_valid;
  assign io_bus.timeout_err = r_timeout_err;

endmodule

// File: tb/tb_trap_sequencer.sv
// Directed bench for trap_sequencer: expected commits queued, checked by a negedge monitor.
module tb_trap_sequencer;
  localparam int unsigned DT = 16;
  localparam int unsigned HO = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  trap_sequencer_if #(.XLEN(32)) bus ();

  trap_sequencer #(
    .XLEN         (32),
    .DRAIN_TIMEOUT(DT),
    .HOLDOFF      (HO)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .io_bus(bus)
  );

  typedef struct {
    bit          is_mret;
    logic [31:0] cause;
    logic [31:0] epc;
    logic [31:0] tval;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_chk = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic push_trap(input logic [31:0] cause, input logic [31:0] epc,
                           input logic [31:0] tval);
    exp_t e;
    e.is_mret = 1'b0;
    e.cause   = cause;
    e.epc     = epc;
    e.tval    = tval;
    sb.push_back(e);
  endtask

  task automatic push_mret();
    exp_t e;
    e.is_mret = 1'b1;
    e.cause   = '0;
    e.epc     = '0;
    e.tval    = '0;
    sb.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every commit pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    if (bus.trap_valid || bus.mret_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_pulse", {30'd0, bus.trap_valid, bus.mret_valid}, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        chk("pulse_kind", {31'd0, bus.mret_valid}, {31'd0, mon_e.is_mret});
        if (!mon_e.is_mret) begin
          chk("trap_cause", bus.trap_cause, mon_e.cause);
          chk("trap_epc", bus.trap_epc, mon_e.epc);
          chk("trap_tval", bus.trap_tval, mon_e.tval);
        end
      end
    end else begin
      chk("outputs_zero_outside_trap", bus.trap_cause | bus.trap_epc | bus.trap_tval, 32'd0);
    end
  end

  task automatic issue_exc(input logic [3:0] cause, input logic [31:0] epc,
                           input logic [31:0] tval);
    bus.exc_cause = cause;
    bus.exc_epc   = epc;
    bus.exc_tval  = tval;
    bus.exc_req   = 1'b1;
    step();
    bus.exc_req = 1'b0;
    chk("exc_to_flush_latency", {31'd0, bus.flush_req}, 32'd1);
  endtask

  task automatic ack_after(input int cycles);
    repeat (cycles) step();
    bus.flush_ack = 1'b1;
    step();
    chk("ack_to_trap", {31'd0, bus.trap_valid}, 32'd1);
    bus.flush_ack = 1'b0;
    step();
    chk("idle_after_trap", {31'd0, bus.busy}, 32'd0);
  endtask

  task automatic wait_flush(input string name);
    int n = 0;
    while (!bus.flush_req && n < 50) begin
      step();
      n++;
    end
    chk(name, {31'd0, bus.flush_req}, 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_chk);
    $fatal(1);
  end

  initial begin
    int n;
    bus.exc_req     = 1'b0;
    bus.exc_cause   = '0;
    bus.exc_epc     = '0;
    bus.exc_tval    = '0;
    bus.mret_req    = 1'b0;
    bus.epc_valid   = 1'b0;
    bus.irq_epc     = '0;
    bus.extern_irpt = 1'b0;
    bus.timer_irpt  = 1'b0;
    bus.soft_irpt   = 1'b0;
    bus.mstatus_mie = 1'b0;
    bus.mie_mask    = '0;
    bus.flush_ack   = 1'b0;

    repeat (3) step();
    chk("rst_flush_req", {31'd0, bus.flush_req}, 32'd0);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_trap_valid", {31'd0, bus.trap_valid}, 32'd0);
    chk("rst_mret_valid", {31'd0, bus.mret_valid}, 32'd0);
    chk("rst_timeout_err", {31'd0, bus.timeout_err}, 32'd0);
    rst = 1'b0;
    step();

    // Exception with delayed flush_ack.
    push_trap(32'h2, 32'h100, 32'hDEAD);
    issue_exc(4'd2, 32'h100, 32'hDEAD);
    chk("exc_busy", {31'd0, bus.busy}, 32'd1);
    ack_after(2);

    // External + timer pending: external wins; irqs drop during drain.
    bus.mstatus_mie = 1'b1;
    bus.mie_mask    = 3'b111;
    bus.epc_valid   = 1'b1;
    bus.irq_epc     = 32'h200;
    bus.extern_irpt = 1'b1;
    bus.timer_irpt  = 1'b1;
    push_trap(32'h8000000B, 32'h200, 32'h0);
    wait_flush("ext_irq_flush");
    bus.extern_irpt = 1'b0;
    bus.timer_irpt  = 1'b0;
    ack_after(2);

    // Same with meie=0: timer taken.
    bus.mie_mask    = 3'b011;
    bus.extern_irpt = 1'b1;
    bus.timer_irpt  = 1'b1;
    push_trap(32'h80000007, 32'h200, 32'h0);
    wait_flush("tim_irq_flush");
    bus.extern_irpt = 1'b0;
    bus.timer_irpt  = 1'b0;
    ack_after(2);

    // Exception and external irq in the same IDLE cycle: exception only.
    bus.mie_mask    = 3'b111;
    bus.extern_irpt = 1'b1;
    push_trap(32'h5, 32'h300, 32'h44);
    issue_exc(4'd5, 32'h300, 32'h44);
    bus.extern_irpt = 1'b0;
    ack_after(1);
    repeat (4) step();
    chk("no_second_trap", {31'd0, bus.busy}, 32'd0);
    chk("timeout_err_clear_before", {31'd0, bus.timeout_err}, 32'd0);

    // Drain timeout.
    push_trap(32'h1, 32'h400, 32'h99);
    issue_exc(4'd1, 32'h400, 32'h99);
    n = 0;
    while (!bus.trap_valid && n < 100) begin
      step();
      n++;
    end
    chk("timeout_latency", n, DT);
    chk("timeout_err_set", {31'd0, bus.timeout_err}, 32'd1);
    step();
    chk("timeout_idle", {31'd0, bus.busy}, 32'd0);
    push_trap(32'h7, 32'h500, 32'h1);
    issue_exc(4'd7, 32'h500, 32'h1);
    ack_after(0);
    chk("timeout_err_sticky", {31'd0, bus.timeout_err}, 32'd1);

    // mret with timer pending: holdoff delays the interrupt.
    bus.irq_epc    = 32'h600;
    bus.timer_irpt = 1'b1;
    bus.mret_req   = 1'b1;
    push_mret();
    push_trap(32'h80000007, 32'h600, 32'h0);
    step();
    chk("mret_pulse", {31'd0, bus.mret_valid}, 32'd1);
    bus.mret_req = 1'b0;
    n = 0;
    while (!bus.flush_req && n < 20) begin
      step();
      n++;
    end
    chk("holdoff_flush_delay", n, HO + 2);
    bus.timer_irpt = 1'b0;
    ack_after(2);
    chk("timeout_err_still_set", {31'd0, bus.timeout_err}, 32'd1);

    // Reset mid-drain: no trap, sticky error cleared.
    issue_exc(4'd3, 32'h700, 32'h3);
    step();
    rst = 1'b1;
    step();
    chk("rst_mid_flush_req", {31'd0, bus.flush_req}, 32'd0);
    chk("rst_mid_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_mid_trap_valid", {31'd0, bus.trap_valid}, 32'd0);
    chk("rst_mid_timeout_err", {31'd0, bus.timeout_err}, 32'd0);
    rst = 1'b0;
    repeat (4) step();
    chk("post_rst_idle", {31'd0, bus.busy}, 32'd0);

    chk("scoreboard_drained", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
